// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin arbiter for the single-port Data memory, with
// optional locked bursts and saturating per-requester grant counters.
module data_mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             lock0,
  input  logic             lock1,
  input  logic             we0,
  input  logic             we1,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [DW-1:0]    wdata0,
  input  logic [DW-1:0]    wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [DW-1:0]    rdata0,
  output logic [DW-1:0]    rdata1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [AW-1:0]    mem_r_addr,
  output logic [AW-1:0]    mem_w_addr,
  output logic             mem_w_en,
  output logic [DW-1:0]    mem_din,
  input  logic [DW-1:0]    mem_dout,
  output logic             busy,
  output logic [CNT_W-1:0] gcnt0,
  output logic [CNT_W-1:0] gcnt1
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_t;

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0]    BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state_r;
  state_t           next_state_s;
  logic             last_r;
  logic [BW-1:0]    bcnt_r;
  logic [BW-1:0]    bcnt_next_s;
  logic [CNT_W-1:0] gcnt0_r;
  logic [CNT_W-1:0] gcnt1_r;
  logic             in_g0_s;
  logic             in_g1_s;

  assign in_g0_s = (state_r == ST_G0);
  assign in_g1_s = (state_r == ST_G1);

  // Handshake outputs come from the registered state, held low while reset is asserted
  assign gnt0    = in_g0_s & ~rst;
  assign gnt1    = in_g1_s & ~rst;
  assign rvalid0 = gnt0 & ~we0;
  assign rvalid1 = gnt1 & ~we1;
  assign busy    = (state_r != ST_IDLE) & ~rst;
  assign rdata0  = mem_dout;
  assign rdata1  = mem_dout;
  assign gcnt0   = gcnt0_r;
  assign gcnt1   = gcnt1_r;

  // Memory port steering: requester 1 only when it holds the grant
  assign mem_r_addr = in_g1_s ? addr1 : addr0;
  assign mem_w_addr = in_g1_s ? addr1 : addr0;
  assign mem_din    = in_g1_s ? wdata1 : wdata0;
  assign mem_w_en   = ~rst & ((in_g0_s & we0) | (in_g1_s & we1));

  // Next-state and burst-count selection
  always_comb begin
    next_state_s = ST_IDLE;
    bcnt_next_s  = {BW{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (req0 && req1) begin
          next_state_s = last_r ? ST_G0 : ST_G1;
        end else if (req0) begin
          next_state_s = ST_G0;
        end else if (req1) begin
          next_state_s = ST_G1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_G0: begin
        if (req0 && lock0 && (bcnt_r < BURST_LAST)) begin
          next_state_s = ST_G0;
          bcnt_next_s  = bcnt_r + BW'(1'b1);
        end else if (req1) begin
          next_state_s = ST_G1;
        end else if (req0) begin
          next_state_s = ST_G0;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_G1: begin
        if (req1 && lock1 && (bcnt_r < BURST_LAST)) begin
          next_state_s = ST_G1;
          bcnt_next_s  = bcnt_r + BW'(1'b1);
        end else if (req0) begin
          next_state_s = ST_G0;
        end else if (req1) begin
          next_state_s = ST_G1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        bcnt_next_s  = {BW{1'b0}};
      end
    endcase
  end

  // State, round-robin pointer, burst counter and saturating grant counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      last_r  <= 1'b1;
      bcnt_r  <= {BW{1'b0}};
      gcnt0_r <= {CNT_W{1'b0}};
      gcnt1_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      bcnt_r  <= bcnt_next_s;
      if (in_g0_s) begin
        last_r <= 1'b0;
      end else if (in_g1_s) begin
        last_r <= 1'b1;
      end
      if (in_g0_s && (gcnt0_r != CNT_MAX)) begin
        gcnt0_r <= gcnt0_r + CNT_W'(1'b1);
      end
      if (in_g1_s && (gcnt1_r != CNT_MAX)) begin
        gcnt1_r <= gcnt1_r + CNT_W'(1'b1);
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Table-driven bench for data_mem_arbiter with a behavioural Data memory,
// plus hand-written sequences for reset-during-write and counter saturation.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, req0, req1, lock0, lock1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_w_en, busy;
  logic [31:0] rdata0, rdata1, mem_r_addr, mem_w_addr, mem_din, mem_dout;
  logic [15:0] gcnt0, gcnt1;
  logic        s_gnt0, s_gnt1, s_rvalid0, s_rvalid1, s_mem_w_en, s_busy;
  logic [31:0] s_rdata0, s_rdata1, s_mem_r_addr, s_mem_w_addr, s_mem_din;
  logic [1:0]  s_gcnt0, s_gcnt1;
  logic        mem_init;
  logic [31:0] mem [0:65535];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .mem_r_addr(mem_r_addr), .mem_w_addr(mem_w_addr),
    .mem_w_en(mem_w_en), .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy),
    .gcnt0(gcnt0), .gcnt1(gcnt1)
  );

  data_mem_arbiter #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(s_gnt0), .gnt1(s_gnt1), .rdata0(s_rdata0), .rdata1(s_rdata1),
    .rvalid0(s_rvalid0), .rvalid1(s_rvalid1), .mem_r_addr(s_mem_r_addr),
    .mem_w_addr(s_mem_w_addr), .mem_w_en(s_mem_w_en), .mem_din(s_mem_din),
    .mem_dout(mem_dout), .busy(s_busy), .gcnt0(s_gcnt0), .gcnt1(s_gcnt1)
  );

  // Data memory model: combinational read, write at the clock edge
  assign mem_dout = mem[mem_r_addr[15:0]];
  always @(posedge clk) begin
    if (mem_init) begin
      mem[5] <= 32'd143;
      mem[9] <= 32'd0;
    end else if (mem_w_en) begin
      mem[mem_w_addr[15:0]] <= mem_din;
    end
  end

  typedef struct {
    bit rst, req0, req1, lock0, we0, we1;
    int addr0, addr1, wdata1;
    bit e_gnt0, e_gnt1, e_wen, e_busy, e_rv0, e_rv1;
    int e_rdata0, e_gcnt0, e_gcnt1;
  } vec_t;

  vec_t vecs [27];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    // rst req0 req1 lock0 we0 we1 addr0 addr1 wdata1 | gnt0 gnt1 wen busy rv0 rv1 rdata0 gcnt0 gcnt1
    vecs[0]  = '{1,0,0,0,0,0, 0,0,0,  0,0,0,0,0,0,   0,  0,0};
    vecs[1]  = '{1,1,0,0,0,0, 5,0,0,  0,0,0,0,0,0,   0,  0,0};
    vecs[2]  = '{0,1,0,0,0,0, 5,0,0,  0,0,0,0,0,0,   0,  0,0};
    vecs[3]  = '{0,0,0,0,0,0, 5,0,0,  1,0,0,1,1,0, 143,  0,0};
    vecs[4]  = '{0,0,0,0,0,0, 5,0,0,  0,0,0,0,0,0,   0,  1,0};
    vecs[5]  = '{0,1,1,0,0,0, 5,0,0,  0,0,0,0,0,0,   0,  1,0};
    vecs[6]  = '{0,1,1,0,0,0, 5,0,0,  0,1,0,1,0,1,   0,  1,0};
    vecs[7]  = '{0,1,1,0,0,0, 5,0,0,  1,0,0,1,1,0, 143,  1,1};
    vecs[8]  = '{0,1,1,0,0,0, 5,0,0,  0,1,0,1,0,1,   0,  2,1};
    vecs[9]  = '{0,1,1,0,0,0, 5,0,0,  1,0,0,1,1,0, 143,  2,2};
    vecs[10] = '{0,1,1,0,0,0, 5,0,0,  0,1,0,1,0,1,   0,  3,2};
    vecs[11] = '{0,0,0,0,0,0, 5,0,0,  1,0,0,1,1,0, 143,  3,3};
    vecs[12] = '{0,0,0,0,0,0, 5,0,0,  0,0,0,0,0,0,   0,  4,3};
    vecs[13] = '{0,0,1,0,0,1, 5,9,77, 0,0,0,0,0,0,   0,  4,3};
    vecs[14] = '{0,0,0,0,0,1, 5,9,77, 0,1,1,1,0,0,   0,  4,3};
    vecs[15] = '{0,1,0,0,0,1, 9,9,77, 0,0,0,0,0,0,   0,  4,4};
    vecs[16] = '{0,0,0,0,0,1, 9,9,77, 1,0,0,1,1,0,  77,  4,4};
    vecs[17] = '{0,0,0,0,0,0, 9,9,0,  0,0,0,0,0,0,   0,  5,4};
    vecs[18] = '{0,1,1,1,0,0, 5,9,0,  0,0,0,0,0,0,   0,  5,4};
    vecs[19] = '{0,1,1,1,0,0, 5,9,0,  0,1,0,1,0,1,   0,  5,4};
    vecs[20] = '{0,1,1,1,0,0, 5,9,0,  1,0,0,1,1,0, 143,  5,5};
    vecs[21] = '{0,1,1,1,0,0, 5,9,0,  1,0,0,1,1,0, 143,  6,5};
    vecs[22] = '{0,1,1,1,0,0, 5,9,0,  1,0,0,1,1,0, 143,  7,5};
    vecs[23] = '{0,1,1,1,0,0, 5,9,0,  1,0,0,1,1,0, 143,  8,5};
    vecs[24] = '{0,1,1,1,0,0, 5,9,0,  0,1,0,1,0,1,   0,  9,5};
    vecs[25] = '{0,0,0,0,0,0, 5,9,0,  1,0,0,1,1,0, 143,  9,6};
    vecs[26] = '{0,0,0,0,0,0, 5,9,0,  0,0,0,0,0,0,   0, 10,6};

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    we0 = 1'b0; we1 = 1'b0; addr0 = 32'd0; addr1 = 32'd0;
    wdata0 = 32'd0; wdata1 = 32'd0; mem_init = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      rst   = vecs[i].rst;   req0 = vecs[i].req0; req1 = vecs[i].req1;
      lock0 = vecs[i].lock0; we0  = vecs[i].we0;  we1  = vecs[i].we1;
      addr0 = vecs[i].addr0; addr1 = vecs[i].addr1; wdata1 = vecs[i].wdata1;
      #2;
      chk($sformatf("row%0d_gnt0", i), gnt0, vecs[i].e_gnt0);
      chk($sformatf("row%0d_gnt1", i), gnt1, vecs[i].e_gnt1);
      chk($sformatf("row%0d_w_en", i), mem_w_en, vecs[i].e_wen);
      chk($sformatf("row%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("row%0d_rvalid0", i), rvalid0, vecs[i].e_rv0);
      chk($sformatf("row%0d_rvalid1", i), rvalid1, vecs[i].e_rv1);
      chk($sformatf("row%0d_gcnt0", i), gcnt0, vecs[i].e_gcnt0);
      chk($sformatf("row%0d_gcnt1", i), gcnt1, vecs[i].e_gcnt1);
      if (vecs[i].e_rv0) chk($sformatf("row%0d_rdata0", i), rdata0, vecs[i].e_rdata0);
    end

    // Reset lands on a G1 write cycle: the write must not commit
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b1; addr1 = 32'd9; wdata1 = 32'd55;
    #2;
    chk("t5_idle_gnt1", gnt1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("t5_rst_w_en", mem_w_en, 1'b0);
    chk("t5_rst_gnt1", gnt1, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0; req1 = 1'b0; we1 = 1'b0;
    #2;
    chk("t5_post_gnt1", gnt1, 1'b0);
    chk("t5_post_busy", busy, 1'b0);
    chk("t5_post_gcnt0", gcnt0, 0);
    chk("t5_post_gcnt1", gcnt1, 0);
    chk("t5_mem9_kept", mem[9], 77);

    // Five back-to-back solo grants to requester 0; 2-bit counter sticks at 3
    @(negedge clk);
    req0 = 1'b1; addr0 = 32'd5; we0 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      req0 = (k < 5);
      #2;
      chk($sformatf("t6_gnt0_%0d", k), gnt0, 1'b1);
      chk($sformatf("t6_sat_gcnt0_%0d", k), s_gcnt0, (k - 1 < 3) ? k - 1 : 3);
    end
    @(negedge clk);
    #2;
    chk("t6_end_gnt0", gnt0, 1'b0);
    chk("t6_gcnt0_wide", gcnt0, 5);
    chk("t6_gcnt0_sat", s_gcnt0, 3);
    chk("t6_gcnt1_sat", s_gcnt1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
